// File: rtl/udp_scan_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : udp_scan_seq                                                 |
// | Description : Self-timed truth-table scan sequencer for a 4-input UDP.     |
// |               Drives {A,B,C,D} through a binary or thermometer sweep,      |
// |               samples E after SETTLE cycles, builds a 16-bit table.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module udp_scan_seq #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    input  logic        E,
    output logic [15:0] table_out,
    output logic [4:0]  ones,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_last_cnt = 4'(SETTLE - 1);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_pattern, w_pattern_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_mode, w_mode_nxt;
    logic [15:0] r_table, w_table_nxt;
    logic [4:0]  r_ones, w_ones_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pattern <= 4'd0;
            r_cnt     <= 4'd0;
            r_mode    <= 1'b0;
            r_table   <= 16'd0;
            r_ones    <= 5'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pattern <= w_pattern_nxt;
            r_cnt     <= w_cnt_nxt;
            r_mode    <= w_mode_nxt;
            r_table   <= w_table_nxt;
            r_ones    <= w_ones_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pattern_nxt = r_pattern;
        w_cnt_nxt     = r_cnt;
        w_mode_nxt    = r_mode;
        w_table_nxt   = r_table;
        w_ones_nxt    = r_ones;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt   = SCAN;
                    w_busy_nxt    = 1'b1;
                    w_done_nxt    = 1'b0;
                    w_table_nxt   = 16'd0;
                    w_ones_nxt    = 5'd0;
                    w_mode_nxt    = mode;
                    w_pattern_nxt = 4'd0;
                    w_cnt_nxt     = 4'd0;
                end
            end
            SCAN: begin
                if (r_cnt < c_last_cnt) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end else begin
                    w_table_nxt[r_pattern] = E;
                    w_ones_nxt             = r_ones + {4'd0, E};
                    w_cnt_nxt              = 4'd0;
                    // Both sweeps end on 1111, so one terminal test covers both modes.
                    if (r_pattern == 4'hF) begin
                        w_state_nxt   = DONE;
                        w_busy_nxt    = 1'b0;
                        w_done_nxt    = 1'b1;
                        w_pattern_nxt = 4'd0;
                    end else if (r_mode) begin
                        w_pattern_nxt = {r_pattern[2:0], 1'b1};
                    end else begin
                        w_pattern_nxt = r_pattern + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign {A, B, C, D} = r_pattern;
    assign table_out    = r_table;
    assign ones         = r_ones;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_udp_scan_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_udp_scan_seq                                              |
// | Description : Directed scoreboard bench for udp_scan_seq (SETTLE 2 and 1). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_udp_scan_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mode, start1, start2;
    logic        a1, b1, c1, d1, e1, a2, b2, c2, d2, e2;
    logic [15:0] tbl1, tbl2;
    logic [4:0]  ones1, ones2;
    logic        busy1, busy2, done1, done2;

    int e_sel;
    int which;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] tbl;
        logic [4:0]  ones;
    } res_t;

    res_t       res_q[$];
    logic [3:0] pat_q[$];

    function automatic logic e_fn(input int s, input logic [3:0] p);
        case (s)
            1:       return ^p;
            2:       return |p;
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign e1 = e_fn(e_sel, {a1, b1, c1, d1});
    assign e2 = e_fn(e_sel, {a2, b2, c2, d2});

    udp_scan_seq #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode),
        .A(a1), .B(b1), .C(c1), .D(d1), .E(e1),
        .table_out(tbl1), .ones(ones1), .busy(busy1), .done(done1)
    );

    udp_scan_seq #(.SETTLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode),
        .A(a2), .B(b2), .C(c2), .D(d2), .E(e2),
        .table_out(tbl2), .ones(ones2), .busy(busy2), .done(done2)
    );

    logic [3:0]  o_pat;
    logic [15:0] o_tbl;
    logic [4:0]  o_ones;
    logic        o_busy, o_done;

    always_comb begin
        if (which == 1) begin
            o_pat = {a1, b1, c1, d1}; o_tbl = tbl1; o_ones = ones1;
            o_busy = busy1; o_done = done1;
        end else begin
            o_pat = {a2, b2, c2, d2}; o_tbl = tbl2; o_ones = ones2;
            o_busy = busy2; o_done = done2;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (which == 1) start1 = v;
        else            start2 = v;
    endtask

    // Reference sweep: expected pattern per cycle and final table/ones.
    task automatic push_scan(input int settle, input logic m);
        logic [15:0] t;
        logic [4:0]  n;
        logic [3:0]  p;
        t = 16'd0; n = 5'd0; p = 4'd0;
        for (int k = 0; k < 16; k++) begin
            for (int s = 0; s < settle; s++) pat_q.push_back(p);
            t[p] = e_fn(e_sel, p);
            n    = n + {4'd0, e_fn(e_sel, p)};
            if (p == 4'hF) break;
            p = m ? {p[2:0], 1'b1} : p + 4'd1;
        end
        res_q.push_back('{tbl: t, ones: n});
    endtask

    task automatic run_scan(input int settle, input logic m, input int poke_at, input int abort_at);
        logic [3:0] exp_p;
        res_t       r;
        int         cyc;
        pat_q.delete();
        push_scan(settle, m);
        @(negedge clk);
        mode = m;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        check("start_busy", o_busy, 1'b1);
        check("start_done", o_done, 1'b0);
        check("start_tbl", o_tbl, 16'd0);
        check("start_ones", o_ones, 5'd0);
        cyc = 0;
        while (pat_q.size() > 0) begin
            exp_p = pat_q.pop_front();
            check($sformatf("pat_c%0d", cyc), o_pat, exp_p);
            check($sformatf("busy_c%0d", cyc), o_busy, 1'b1);
            check($sformatf("done_c%0d", cyc), o_done, 1'b0);
            if (cyc == abort_at) begin
                #2 rst = 1'b1;
                #1;
                check("rst_pat", o_pat, 4'd0);
                check("rst_tbl", o_tbl, 16'd0);
                check("rst_ones", o_ones, 5'd0);
                check("rst_busy", o_busy, 1'b0);
                check("rst_done", o_done, 1'b0);
                pat_q.delete();
                res_q.delete();
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (cyc == poke_at) begin
                mode = ~m;
                set_start(1'b1);
            end
            @(posedge clk); #1;
            set_start(1'b0);
            cyc++;
        end
        check("end_done", o_done, 1'b1);
        check("end_busy", o_busy, 1'b0);
        check("end_pat", o_pat, 4'd0);
        check("end_cycles", cyc, (m ? 5 : 16) * settle);
        if (res_q.size() == 0) begin
            check("res_q_empty", 1'b1, 1'b0);
        end else begin
            r = res_q.pop_front();
            check("end_tbl", o_tbl, r.tbl);
            check("end_ones", o_ones, r.ones);
        end
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; mode = 1'b0;
        e_sel = 0; which = 2;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pat2", {a2, b2, c2, d2}, 4'd0);
        check("reset_tbl2", tbl2, 16'd0);
        check("reset_ones2", ones2, 5'd0);
        check("reset_busy2", busy2, 1'b0);
        check("reset_done2", done2, 1'b0);
        check("reset_busy1", busy1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy2", busy2, 1'b0);

        // E tied low, SETTLE=2, binary
        which = 2; e_sel = 0;
        run_scan(2, 1'b0, -1, -1);
        check("zero_tbl", tbl2, 16'h0000);
        check("zero_ones", ones2, 5'd0);

        // parity UDP, SETTLE=1, binary
        which = 1; e_sel = 1;
        run_scan(1, 1'b0, -1, -1);
        check("xor_tbl", tbl1, 16'h6996);
        check("xor_ones", ones1, 5'd8);

        // restart straight out of DONE with E tied high
        e_sel = 3;
        run_scan(1, 1'b0, -1, -1);
        check("ones_tbl", tbl1, 16'hFFFF);
        check("ones_cnt", ones1, 5'd16);

        // OR UDP, thermometer sweep, then DONE must hold
        which = 2; e_sel = 2;
        run_scan(2, 1'b1, -1, -1);
        check("or_tbl", tbl2, 16'h808A);
        check("or_ones", ones2, 5'd4);
        repeat (3) @(posedge clk);
        #1;
        check("hold_tbl", tbl2, 16'h808A);
        check("hold_done", done2, 1'b1);

        // start with mode=1 mid binary scan must be ignored
        e_sel = 0;
        run_scan(2, 1'b0, 7, -1);

        // async reset while 0101 is settling, then a clean scan
        e_sel = 1;
        run_scan(2, 1'b0, -1, 10);
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_busy", busy2, 1'b0);
        check("post_rst_done", done2, 1'b0);
        check("post_rst_pat", {a2, b2, c2, d2}, 4'd0);
        run_scan(2, 1'b0, -1, -1);
        check("after_rst_tbl", tbl2, 16'h6996);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/udp_scan_seq.md
# udp_scan_seq

Truth-table scan sequencer that sits directly upstream of the 4-input UDP circuit and also consumes its output. On `start` it drives the UDP inputs A, B, C, D through a pattern sequence. It holds each pattern for a fixed settle time, then samples E into a 16-bit captured truth table. It replaces hand-written `#10` stimulus with a synthesizable, self-timed characterization stage.

## Interface
Parameters:
- `SETTLE`, default 2: cycles each pattern is held before E is sampled; legal range 1..15.

Ports:
- `clk`  input  1  single clock, all state updates on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `start`  input  1  begin scan; accepted only in IDLE or DONE
- `mode`  input  1  latched on accepted start: 0 = binary sweep (16 patterns), 1 = thermometer sweep (0000, 0001, 0011, 0111, 1111)
- `A`, `B`, `C`, `D`  output  1 each  UDP inputs; {A,B,C,D} = current pattern, A is MSB
- `E`  input  1  UDP output being characterized
- `table_out`  output  16  captured truth table; bit k = E sampled while {A,B,C,D} == k
- `ones`  output  5  count of captured E == 1 samples in the current scan, 0..16
- `busy`  output  1  high while scanning
- `done`  output  1  high from scan completion until next accepted start or reset

## Operation
- States: IDLE, SCAN, DONE.
- Reset (async, immediate, any state) sets:
  - state = IDLE
  - {A,B,C,D} = 0000
  - table_out = 0, ones = 0
  - busy = 0, done = 0
  - internal index and settle counter = 0
- IDLE/DONE, start = 1 at an edge: the scan starts at that edge.
  - state = SCAN, busy = 1, done = 0.
  - table_out = 0, ones = 0.
  - mode latched; pattern index = 0; settle counter = 0.
- SCAN, each edge:
  - If counter < SETTLE-1, counter increments.
  - If counter == SETTLE-1, sample: table_out[pattern] <= E, ones <= ones + E. Then:
    - pattern == 1111: go to DONE (busy = 0, done = 1, {A,B,C,D} = 0000).
    - Otherwise advance the pattern and clear the counter. Binary: pattern + 1. Thermometer: (pattern << 1) | 1.
- Both modes terminate on pattern 1111. In thermometer mode, table bits never visited stay 0.
- `start` while in SCAN is ignored; the latched mode is unchanged.
- DONE holds table_out and ones until the next accepted start or reset.
- `ones` never exceeds 16; a 5-bit width is sufficient, so no saturation logic is needed.

## Timing
- Registered outputs, no combinational path from inputs to outputs.
- Start accepted at edge 0: pattern 0000 appears after edge 0.
- Each pattern is driven for exactly SETTLE cycles. E is sampled at the SETTLE-th edge after that pattern first appears. The UDP plus any wiring must therefore settle within SETTLE cycles.
- The new pattern, the updated table bit and the updated ones all appear after the same edge.
- Completion: done = 1 after edge 16·SETTLE (binary) or 5·SETTLE (thermometer), counted from the start edge.
- Back-to-back: start held high in DONE restarts at the next edge, so done is high for exactly one cycle.
- Reset asserted mid-scan clears all outputs asynchronously. After reset release, the block stays in IDLE until a start.

## Test plan
- UDP as specified (E constant 0), SETTLE = 2, binary: done after 32 cycles, table_out = 0x0000, ones = 0, A..D traverse 0000..1111 with each value held 2 cycles.
- Behavioral E = A^B^C^D, SETTLE = 1, binary: table_out = 0x6996, ones = 8, done after 16 cycles.
- E = A|B|C|D, SETTLE = 2, mode = 1: patterns 0000, 0001, 0011, 0111, 1111 (the existing testbench sequence); table_out = 0x808A, ones = 4, done after 10 cycles.
- Start pulsed again with mode = 1 during a binary scan: ignored, so the sweep stays binary and done still arrives at cycle 32.
- Reset asserted while pattern = 0101, mid-settle: A..D = 0000, table_out = 0, ones = 0, busy = 0 immediately, without waiting for a clock. A subsequent start completes a normal scan.
- Start in DONE after a 0x6996 scan, with E now tied to 1: table_out and ones are cleared at the start edge and end at 0xFFFF and 16.
